keyspace_scheduler: RTL and testbench
=====================================

# keyspace_scheduler

Multi-lane key-space scheduler for the DES code breaker. It splits the key range [base_key, limit_key] into fixed-size blocks and hands them round-robin to LANES parallel DES cracker lanes. It tracks which lanes have blocks in flight, stops all lanes on the first match, and reports the matching key and lane. It replaces the single-engine up/store/found sequencing whenever more than one cracker lane is instantiated.

## Interface
- KEY_W, 56, key width in bits
- LANES, 4, number of cracker lanes (2..16)
- BLK_W, 16, log2 of keys per block; blocks are 2^BLK_W keys
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level; run while high, dropping it returns to IDLE
- base_key  in  KEY_W  first key; sampled on the IDLE->DISPATCH edge
- limit_key  in  KEY_W  last key to cover (inclusive); sampled with base_key
- lane_ready  in  LANES  lane can accept a block
- lane_done  in  LANES  one-cycle pulse: lane finished its block, no match
- lane_hit  in  LANES  one-cycle pulse: lane found a match
- hit_key  in  LANES*KEY_W  matched key per lane; lane i at bits [i*KEY_W +: KEY_W], valid with lane_hit[i]
- lane_go  out  LANES  registered one-hot pulse: dispatch block to lane
- blk_key  out  KEY_W  registered first key of the dispatched block; valid with lane_go
- abort  out  1  lanes drop current work
- busy  out  1  state is DISPATCH or DRAIN
- found  out  1  match latched
- exhausted  out  1  range covered with no match
- found_key  out  KEY_W  latched matching key
- found_lane  out  $clog2(LANES)  lane that produced found_key
- blocks_done  out  32  completed-block count (see Configuration)

## Operation
- States: IDLE, DISPATCH, DRAIN, FOUND, EXHAUST.
- IDLE: start=1 -> DISPATCH. Load next_key (KEY_W+1 bits) with base_key and latch limit_key. Clear the inflight mask, found_key and found_lane.
- DISPATCH: each cycle, grant at most one lane i with lane_ready[i] & ~inflight[i].
  - Round-robin: search starts at the lane after the last grant; after reset, search starts at lane 0.
  - On grant: set inflight[i], register lane_go[i]=1 and blk_key=next_key, then next_key += 2^BLK_W.
  - When next_key > limit_key, or next_key carries out of KEY_W, -> DRAIN. The last block may extend past limit_key. Blocks are never truncated.
- lane_done[i] clears inflight[i] in any active state and increments blocks_done.
- DRAIN: no grants. inflight == 0 -> EXHAUST.
- Any lane_hit in DISPATCH or DRAIN -> FOUND.
  - Latch hit_key and lane index. On simultaneous hits, the lowest index wins.
  - A grant in the same cycle is suppressed.
  - hit and done from the same lane in the same cycle: hit wins.
- FOUND: found=1, abort=1, inflight cleared. start=0 -> IDLE.
- EXHAUST: exhausted=1. start=0 -> IDLE.
- start=0 in DISPATCH or DRAIN: -> IDLE, inflight cleared, abort=1 for exactly one cycle (the first IDLE cycle).
- lane_done or lane_hit from a lane whose inflight bit is clear is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - next_key 0, inflight 0, RR pointer 0.
  - blocks_done 0.
- start sampled 1 at edge E0 -> DISPATCH. First lane_go is visible after edge E1.
- Sustained dispatch rate: one block per cycle while eligible lanes exist.
- lane_hit at edge E -> found, found_key and abort high after E. They hold until start=0 is sampled. found and abort drop after the edge that enters IDLE.
- lane_done clearing inflight[i] at edge E makes lane i grantable at edge E+1.
- lane_go is exactly one cycle wide. The same lane is never granted twice without an intervening done or hit.

## Configuration
- KEYSCHED_PROGRESS_EN defined: blocks_done is a 32-bit saturating counter of accepted lane_done pulses. It is cleared on reset and on IDLE->DISPATCH.
- Not defined: blocks_done is tied to 0 and the counter logic is absent. The port stays present.

## Test plan
- LANES=4, BLK_W=4, base=0x00, limit=0x3F, all lanes ready, done 3 cycles after each go -> blk_key 0x00,0x10,0x20,0x30 to lanes 0,1,2,3, then DRAIN -> EXHAUST. blocks_done=4 with the macro, 0 without.
- Same setup, lane 2 pulses hit with hit_key=0x25 -> found=1, found_key=0x25, found_lane=2, abort=1, no further lane_go. start=0 -> IDLE, all outputs 0.
- Lanes 1 and 3 hit in the same cycle (keys 0x11, 0x33) -> found_lane=1, found_key=0x11.
- Only lane 3 ready, base=0xFF…F0, limit=all-ones -> one block to lane 3, carry out -> DRAIN, done -> EXHAUST.
- start dropped while two blocks are in flight -> IDLE next cycle, abort high exactly one cycle. A late done is ignored. Restart dispatches again from the new base_key.
- reset asserted mid-DISPATCH, asynchronously between edges -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/keyspace_scheduler.sv
// rtl/keyspace_scheduler.sv - multi-lane DES key-space block scheduler
//
// Splits [base_key, limit_key] into 2^BLK_W-key blocks and deals them
// round-robin to LANES cracker lanes, stopping everything on the first hit.
//
// Optional feature macro: KEYSCHED_PROGRESS_EN (enables blocks_done counter).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               level run request; low returns to IDLE
//   base_key, limit_key key range, sampled when leaving IDLE
//   lane_ready          per-lane can-accept flag
//   lane_done, lane_hit per-lane completion / match pulses
//   hit_key             per-lane matched key, lane i at [i*KEY_W +: KEY_W]
//   lane_go, blk_key    one-hot dispatch pulse and block first key
//   abort               lanes drop current work
//   busy                DISPATCH or DRAIN
//   found, exhausted    terminal status
//   found_key/lane      latched match
//   blocks_done         completed-block count (0 unless feature enabled)

module keyspace_scheduler #(
  parameter int KEY_W = 56,
  parameter int LANES = 4,
  parameter int BLK_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [KEY_W-1:0]         base_key,
  input  logic [KEY_W-1:0]         limit_key,
  input  logic [LANES-1:0]         lane_ready,
  input  logic [LANES-1:0]         lane_done,
  input  logic [LANES-1:0]         lane_hit,
  input  logic [LANES*KEY_W-1:0]   hit_key,
  output logic [LANES-1:0]         lane_go,
  output logic [KEY_W-1:0]         blk_key,
  output logic                     abort,
  output logic                     busy,
  output logic                     found,
  output logic                     exhausted,
  output logic [KEY_W-1:0]         found_key,
  output logic [$clog2(LANES)-1:0] found_lane,
  output logic [31:0]              blocks_done
);

  localparam int LW = $clog2(LANES);
  localparam logic [KEY_W:0] BLK_STEP = (KEY_W+1)'(1) << BLK_W;

  typedef enum logic [2:0] {
    S_IDLE, S_DISPATCH, S_DRAIN, S_FOUND, S_EXHAUST
  } state_t;

  state_t           state, state_nx;
  logic [KEY_W:0]   next_key;     // extra bit catches carry out of the key space
  logic [KEY_W-1:0] limit_q;
  logic [LANES-1:0] inflight;
  logic [LW-1:0]    rr_start;     // lane where the next grant search begins
  logic             abort_q;      // one-cycle abort after a dropped start

  logic             active;
  logic [LANES-1:0] hit_acc, done_acc, eligible, grant_oh;
  logic             any_hit, grant_vld, grant, past_limit, inc_past;
  logic [LW-1:0]    grant_idx, hit_idx;
  logic [KEY_W:0]   next_key_inc;
  logic [KEY_W-1:0] hit_sel;

  assign active       = (state == S_DISPATCH) || (state == S_DRAIN);
  // Pulses from lanes with nothing in flight are stale and dropped.
  assign hit_acc      = lane_hit & inflight;
  // A lane reporting hit and done together is treated as a hit only.
  assign done_acc     = lane_done & inflight & ~lane_hit;
  assign any_hit      = |hit_acc;
  assign eligible     = lane_ready & ~inflight;
  assign next_key_inc = next_key + BLK_STEP;
  assign past_limit   = next_key > {1'b0, limit_q};
  assign inc_past     = next_key_inc > {1'b0, limit_q};
  assign grant_oh     = grant ? (LANES'(1) << grant_idx) : '0;
  assign hit_sel      = hit_key[int'(hit_idx)*KEY_W +: KEY_W];

  // Round-robin search starting at rr_start.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = int'(rr_start) + k;
      if (idx >= LANES) idx = idx - LANES;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = LW'(idx);
      end
    end
  end

  // Lowest-index accepted hit wins.
  always_comb begin
    hit_idx = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (hit_acc[i]) hit_idx = LW'(i);
    end
  end

  // A hit in the same cycle suppresses the grant.
  assign grant = (state == S_DISPATCH) && start && !any_hit && !past_limit && grant_vld;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_DISPATCH;
      S_DISPATCH: begin
        if (!start)                 state_nx = S_IDLE;
        else if (any_hit)           state_nx = S_FOUND;
        else if (past_limit)        state_nx = S_DRAIN;
        else if (grant && inc_past) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!start)             state_nx = S_IDLE;
        else if (any_hit)       state_nx = S_FOUND;
        else if (inflight == 0) state_nx = S_EXHAUST;
      end
      S_FOUND, S_EXHAUST: if (!start) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      next_key   <= '0;
      limit_q    <= '0;
      inflight   <= '0;
      rr_start   <= '0;
      abort_q    <= 1'b0;
      lane_go    <= '0;
      blk_key    <= '0;
      found_key  <= '0;
      found_lane <= '0;
    end else begin
      state   <= state_nx;
      abort_q <= active && !start;
      lane_go <= grant_oh;
      blk_key <= grant ? next_key[KEY_W-1:0] : '0;
      if (state == S_IDLE && start) begin
        next_key   <= {1'b0, base_key};
        limit_q    <= limit_key;
        inflight   <= '0;
        found_key  <= '0;
        found_lane <= '0;
      end else if (active) begin
        if (!start || any_hit) inflight <= '0;
        else                   inflight <= (inflight & ~done_acc) | grant_oh;
        if (start && any_hit) begin
          found_key  <= hit_sel;
          found_lane <= hit_idx;
        end
        if (grant) begin
          next_key <= next_key_inc;
          rr_start <= (int'(grant_idx) == LANES-1) ? '0 : grant_idx + LW'(1);
        end
      end else if (state == S_FOUND && !start) begin
        found_key  <= '0;
        found_lane <= '0;
      end
    end
  end

  assign busy      = active;
  assign found     = (state == S_FOUND);
  assign exhausted = (state == S_EXHAUST);
  assign abort     = (state == S_FOUND) || abort_q;

`ifdef KEYSCHED_PROGRESS_EN
  logic [32:0] blocks_sum;
  assign blocks_sum = {1'b0, blocks_done} + 33'($countones(done_acc));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        blocks_done <= '0;
    else if (state == S_IDLE && start) blocks_done <= '0;
    else if (active)                  blocks_done <= blocks_sum[32] ? 32'hFFFF_FFFF : blocks_sum[31:0];
  end
`else
  assign blocks_done = '0;
`endif

endmodule

// File: tb/tb_keyspace_scheduler.sv
// tb/tb_keyspace_scheduler.sv - directed self-checking bench for keyspace_scheduler

module tb_keyspace_scheduler;

  localparam int KW = 8;
  localparam int NL = 4;
`ifdef KEYSCHED_PROGRESS_EN
  localparam int PROG = 1;
`else
  localparam int PROG = 0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   base_key = '0;
  logic [KW-1:0]   limit_key = '0;
  logic [NL-1:0]   lane_ready = '0;
  logic [NL-1:0]   lane_done, lane_hit;
  logic [NL*KW-1:0] hit_key;
  logic [NL-1:0]   lane_go;
  logic [KW-1:0]   blk_key;
  logic            abort, busy, found, exhausted;
  logic [KW-1:0]   found_key;
  logic [1:0]      found_lane;
  logic [31:0]     blocks_done;

  // Lane responder model plus manual overrides from the main sequence.
  logic [NL-1:0]    resp_done = '0, resp_hit = '0, man_done = '0, man_hit = '0;
  logic [NL*KW-1:0] resp_key = '0, man_key = '0;
  logic             auto_en = 1'b1;
  int               hit_lane = -1;
  logic [KW-1:0]    hit_val = '0;
  int               cnt [NL] = '{0, 0, 0, 0};
  int               go_lane [$];
  int               go_key [$];

  int vec_cnt = 0;
  int err_cnt = 0;

  assign lane_done = resp_done | man_done;
  assign lane_hit  = resp_hit | man_hit;
  assign hit_key   = (man_hit != 0) ? man_key : resp_key;

  always #5 clk = ~clk;

  keyspace_scheduler #(.KEY_W(KW), .LANES(NL), .BLK_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_key(base_key), .limit_key(limit_key),
    .lane_ready(lane_ready), .lane_done(lane_done), .lane_hit(lane_hit), .hit_key(hit_key),
    .lane_go(lane_go), .blk_key(blk_key), .abort(abort), .busy(busy), .found(found),
    .exhausted(exhausted), .found_key(found_key), .found_lane(found_lane),
    .blocks_done(blocks_done)
  );

  // Each granted lane answers 3 cycles after its go pulse.
  always @(negedge clk) begin
    resp_done = '0;
    resp_hit  = '0;
    for (int i = 0; i < NL; i++) begin
      if (lane_go[i]) begin
        cnt[i] = 3;
        go_lane.push_back(i);
        go_key.push_back(int'(blk_key));
      end else if (cnt[i] != 0) begin
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0 && auto_en) begin
          if (i == hit_lane) begin
            resp_hit[i] = 1'b1;
            resp_key[i*KW +: KW] = hit_val;
          end else begin
            resp_done[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // which: 0 = wait for exhausted, 1 = wait for found
  task automatic wait_flag(input string tag, input int which, input int max_cyc);
    int n;
    n = 0;
    while (((which == 0) ? exhausted : found) !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, ((which == 0) ? exhausted : found), 1);
  endtask

  task automatic wait_grants(input string tag, input int target, input int max_cyc);
    int n;
    n = 0;
    while (go_lane.size() < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, (go_lane.size() >= target), 1);
  endtask

  task automatic check_all_zero(input string tag, input logic [31:0] exp_bd);
    check({tag, "_go"},    lane_go, 0);
    check({tag, "_blk"},   blk_key, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_exh"},   exhausted, 0);
    check({tag, "_fkey"},  found_key, 0);
    check({tag, "_flane"}, found_lane, 0);
    check({tag, "_bd"},    blocks_done, exp_bd);
  endtask

  initial begin
    int snap;
    repeat (2) @(negedge clk);
    check_all_zero("rst", 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: full range 0x00..0x3F over 4 lanes, then drain and exhaust
    snap = go_lane.size();
    base_key = 8'h00; limit_key = 8'h3F; lane_ready = 4'hF; start = 1'b1;
    @(negedge clk);
    check("t1_e0_go", lane_go, 0);
    check("t1_e0_busy", busy, 1);
    @(negedge clk);
    check("t1_e1_go", lane_go, 4'b0001);
    check("t1_e1_blk", blk_key, 8'h00);
    wait_flag("t1_exh_wait", 0, 40);
    check("t1_ngo", go_lane.size() - snap, 4);
    for (int i = 0; i < 4; i++) begin
      if (go_lane.size() > snap + i) begin
        check($sformatf("t1_lane%0d", i), go_lane[snap+i], i);
        check($sformatf("t1_key%0d", i), go_key[snap+i], i * 16);
      end
    end
    check("t1_busy", busy, 0);
    check("t1_bd", blocks_done, PROG ? 4 : 0);
    start = 1'b0;
    @(negedge clk);
    check("t1_idle_exh", exhausted, 0);

    // 2: lane 2 reports a hit with key 0x25
    snap = go_lane.size();
    hit_lane = 2; hit_val = 8'h25; start = 1'b1;
    wait_flag("t2_found_wait", 1, 40);
    check("t2_fkey", found_key, 8'h25);
    check("t2_flane", found_lane, 2);
    check("t2_abort", abort, 1);
    check("t2_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("t2_ngo", go_lane.size() - snap, 4);
    check("t2_hold", found, 1);
    check("t2_bd", blocks_done, PROG ? 2 : 0);
    hit_lane = -1;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("t2_idle", PROG ? 2 : 0);

    // 3: simultaneous hits on lanes 1 and 3, lowest wins
    auto_en = 1'b0;
    snap = go_lane.size();
    start = 1'b1;
    wait_grants("t3_grants", snap + 4, 30);
    man_key = {8'h33, 8'h00, 8'h11, 8'h00};
    man_hit = 4'b1010;
    @(negedge clk);
    man_hit = '0;
    check("t3_found", found, 1);
    check("t3_flane", found_lane, 1);
    check("t3_fkey", found_key, 8'h11);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // 4: top of key space, only lane 3 ready, carry out ends dispatch
    auto_en = 1'b1;
    snap = go_lane.size();
    base_key = 8'hF0; limit_key = 8'hFF; lane_ready = 4'b1000; start = 1'b1;
    wait_flag("t4_exh_wait", 0, 40);
    check("t4_ngo", go_lane.size() - snap, 1);
    if (go_lane.size() > snap) begin
      check("t4_lane", go_lane[snap], 3);
      check("t4_key", go_key[snap], 8'hF0);
    end
    check("t4_bd", blocks_done, PROG ? 1 : 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // 5: drop start with two blocks in flight
    auto_en = 1'b0;
    snap = go_lane.size();
    base_key = 8'h40; limit_key = 8'hFF; lane_ready = 4'b0011; start = 1'b1;
    wait_grants("t5_grants", snap + 2, 30);
    start = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_abort1", abort, 1);
    @(negedge clk);
    check("t5_abort2", abort, 0);
    man_done = 4'b0001;
    @(negedge clk);
    man_done = '0;
    @(negedge clk);
    check("t5_late_done_bd", blocks_done, 0);
    check("t5_late_done_busy", busy, 0);
    base_key = 8'h80; lane_ready = 4'hF; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_rst_go", lane_go, 4'b0100);
    check("t5_rst_blk", blk_key, 8'h80);

    // 6: asynchronous reset between edges while dispatching
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_all_zero("t6", 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
